// File: rtl/alu_muldiv_control.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_control
// Description : ALU control decode plus an iterative RV32M multiply/divide
//               engine for the execute stage of a single-cycle RISC-V core.
//               The engine holds the pipeline (stall) while it iterates and
//               pulses md_valid for one cycle when md_result is final.
// Ports       : clk, reset (async, active-low)
//               aluop/func3/func7   -> aluoperation, is_md (combinational)
//               valid_in, kill      -> engine start / abort
//               rs1_data, rs2_data  -> engine operands
//               stall, md_valid, md_result -> engine status and result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_control #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] ALUOP_R    = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            aluop,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  valid_in,
    input  logic                  kill,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic [3:0]            aluoperation,
    output logic                  is_md,
    output logic                  stall,
    output logic                  md_valid,
    output logic [DATA_WIDTH-1:0] md_result
);

    localparam int c_W  = DATA_WIDTH;
    localparam int c_CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_W-1:0]  c_MOST_NEG = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [c_W-1:0]  c_ONES     = {c_W{1'b1}};

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [2:0]       r_op;
    logic             r_neg;
    logic [c_W-1:0]   r_opnd;      // multiplicand (mul) or divisor (div)
    logic [2*c_W-1:0] r_acc;       // {hi, lo}: product, or {remainder, quotient}
    logic             r_md_valid;
    logic [c_W-1:0]   r_md_result;

    // ------------------------------------------------------------------
    // ALU operation decode
    // ------------------------------------------------------------------
    always_comb begin
        aluoperation = 4'b1111;
        if (aluop == ALUOP_R) begin
            if (func7 == 7'b0000001) begin
                aluoperation = 4'b1010;
            end else if (func7 == 7'b0100000) begin
                if (func3 == 3'b000) aluoperation = 4'b0001;
            end else if (func7 == 7'b0000000) begin
                case (func3)
                    3'b000:  aluoperation = 4'b0000;
                    3'b100:  aluoperation = 4'b0010;
                    3'b110:  aluoperation = 4'b0011;
                    3'b111:  aluoperation = 4'b0100;
                    3'b001:  aluoperation = 4'b0111;
                    3'b101:  aluoperation = 4'b1000;
                    3'b010:  aluoperation = 4'b1001;
                    default: aluoperation = 4'b1111;
                endcase
            end
        end else begin
            case (aluop)
                4'b0001: begin
                    case (func3)
                        3'b000:  aluoperation = 4'b0000;
                        3'b100:  aluoperation = 4'b0010;
                        3'b110:  aluoperation = 4'b0011;
                        3'b111:  aluoperation = 4'b0100;
                        3'b001:  aluoperation = 4'b0101;
                        3'b101:  aluoperation = 4'b0110;
                        3'b010:  aluoperation = 4'b1001;
                        default: aluoperation = 4'b1111;
                    endcase
                end
                4'b0011: aluoperation = 4'b0001;
                4'b0111: if (func3 == 3'b010) aluoperation = 4'b0000;
                4'b0010: if (func3 == 3'b010) aluoperation = 4'b0000;
                4'b1000: if (func3 == 3'b000) aluoperation = 4'b0000;
                4'b0110, 4'b0100, 4'b0101: aluoperation = 4'b0000;
                default: aluoperation = 4'b1111;
            endcase
        end
    end

    assign is_md = (aluop == ALUOP_R) && (func7 == 7'b0000001);
    assign stall = valid_in & is_md & (r_state != c_DONE);

    // ------------------------------------------------------------------
    // Operand preparation at acceptance
    // ------------------------------------------------------------------
    logic           w_start;
    logic           w_a_neg;
    logic           w_b_neg;
    logic           w_res_neg;
    logic [c_W-1:0] w_a_mag;
    logic [c_W-1:0] w_b_mag;
    logic           w_div0;
    logic           w_ovf;
    logic [c_W-1:0] w_special_res;

    assign w_start = valid_in & is_md & ~kill & (r_state == c_IDLE);

    // rs1 is signed for mulh, mulhsu, div, rem; rs2 for mulh, div, rem.
    // Plain mul is left unsigned: its low half does not depend on signedness.
    assign w_a_neg = rs1_data[c_W-1] &
                     ((func3 == 3'b001) | (func3 == 3'b010) | (func3 == 3'b100) | (func3 == 3'b110));
    assign w_b_neg = rs2_data[c_W-1] &
                     ((func3 == 3'b001) | (func3 == 3'b100) | (func3 == 3'b110));
    // Remainder takes the dividend's sign only.
    assign w_res_neg = w_a_neg ^ (w_b_neg & (func3 != 3'b110));
    assign w_a_mag   = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag   = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;

    assign w_div0 = func3[2] & (rs2_data == '0);
    assign w_ovf  = ((func3 == 3'b100) | (func3 == 3'b110)) &
                    (rs1_data == c_MOST_NEG) & (rs2_data == c_ONES);
    assign w_special_res = w_div0 ? (func3[1] ? rs1_data : c_ONES)
                                  : (func3[1] ? '0 : c_MOST_NEG);

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [c_W:0]     w_msum;
    logic [2*c_W-1:0] w_mul_nxt;
    logic [c_W:0]     w_rem_sh;
    logic [c_W:0]     w_diff;
    logic [2*c_W-1:0] w_div_nxt;
    logic [2*c_W-1:0] w_acc_nxt;
    logic [2*c_W-1:0] w_prod_s;
    logic [c_W-1:0]   w_quo_s;
    logic [c_W-1:0]   w_rem_s;
    logic [c_W-1:0]   w_final;

    // Multiplier sits in the low half and is consumed LSB first while the
    // partial product shifts in from the top.
    assign w_msum    = {1'b0, r_acc[2*c_W-1:c_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_msum, r_acc[c_W-1:1]};

    // Partial remainder shifted left with the next dividend bit; needs one
    // extra bit before the trial subtraction.
    assign w_rem_sh  = r_acc[2*c_W-1:c_W-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_div_nxt = (w_rem_sh >= {1'b0, r_opnd})
                     ? {w_diff[c_W-1:0],   r_acc[c_W-2:0], 1'b1}
                     : {w_rem_sh[c_W-1:0], r_acc[c_W-2:0], 1'b0};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    assign w_prod_s = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign w_quo_s  = r_neg ? (~w_acc_nxt[c_W-1:0] + 1'b1) : w_acc_nxt[c_W-1:0];
    assign w_rem_s  = r_neg ? (~w_acc_nxt[2*c_W-1:c_W] + 1'b1) : w_acc_nxt[2*c_W-1:c_W];

    always_comb begin
        w_final = w_prod_s[c_W-1:0];
        case (r_op)
            3'b000:                 w_final = w_prod_s[c_W-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*c_W-1:c_W];
            3'b100, 3'b101:         w_final = w_quo_s;
            default:                w_final = w_rem_s;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_md_valid  <= 1'b0;
            r_md_result <= '0;
        end else begin
            r_md_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_op   <= func3;
                        r_neg  <= w_res_neg;
                        r_cnt  <= c_CNT_LOAD;
                        r_opnd <= func3[2] ? w_b_mag : w_a_mag;
                        r_acc  <= {{c_W{1'b0}}, (func3[2] ? w_a_mag : w_b_mag)};
                        if (w_div0 | w_ovf) begin
                            r_state     <= c_DONE;
                            r_md_valid  <= 1'b1;
                            r_md_result <= w_special_res;
                        end else begin
                            r_state <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    // Abort wins over a completion in the same cycle.
                    if (kill) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_CNT_ONE) begin
                            r_state     <= c_DONE;
                            r_md_valid  <= 1'b1;
                            r_md_result <= w_final;
                        end
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign md_valid  = r_md_valid;
    assign md_result = r_md_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_control
// Description : Self-checking bench for alu_muldiv_control (DATA_WIDTH=32).
//               Directed decode, arithmetic, special-case, kill and reset
//               steps followed by random M ops against a 64-bit arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_control;

    logic        clk;
    logic        reset;
    logic [3:0]  aluop;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        valid_in;
    logic        kill;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  aluoperation;
    logic        is_md;
    logic        stall;
    logic        md_valid;
    logic [31:0] md_result;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_exp;

    alu_muldiv_control #(.DATA_WIDTH(32), .ALUOP_R(4'b0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .aluop        (aluop),
        .func3        (func3),
        .func7        (func7),
        .valid_in     (valid_in),
        .kill         (kill),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .aluoperation (aluoperation),
        .is_md        (is_md),
        .stall        (stall),
        .md_valid     (md_valid),
        .md_result    (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with wide arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sb);               return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);               return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);               return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};    return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Presents an M op at a negedge and follows it to completion; returns on
    // the negedge after the md_valid cycle with valid_in dropped.
    task automatic do_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] exp;
        int          lat;
        int          cyc;
        int          nstall;
        bit          seen;
        exp      = ref_md(f3, a, b);
        lat      = is_special(f3, a, b) ? 1 : 33;
        aluop    = 4'b0000;
        func7    = 7'b0000001;
        func3    = f3;
        rs1_data = a;
        rs2_data = b;
        valid_in = 1'b1;
        kill     = 1'b0;
        #1;
        nstall = stall ? 1 : 0;
        seen   = 1'b0;
        cyc    = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (md_valid) seen = 1'b1;
            else if (stall) nstall++;
        end
        check({tag, " md_valid seen"}, 32'(seen), 32'd1);
        check({tag, " latency"},       32'(cyc), 32'(lat));
        check({tag, " stall cycles"},  32'(nstall), 32'(lat));
        check({tag, " stall in done"}, 32'(stall), 32'd0);
        check({tag, " result"},        md_result, exp);
        valid_in = 1'b0;
        @(negedge clk);
        check({tag, " valid pulse"},   32'(md_valid), 32'd0);
        check({tag, " result hold"},   md_result, exp);
        last_exp = exp;
    endtask

    // Decode vectors: {aluop, func3, func7} -> {aluoperation, is_md}
    logic [3:0] dv_aluop [14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                  4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b1111, 4'b0000, 4'b0001};
    logic [2:0] dv_f3    [14] = '{3'b000, 3'b000, 3'b100, 3'b111, 3'b010, 3'b001, 3'b101,
                                  3'b001, 3'b000, 3'b010, 3'b001, 3'b000, 3'b110, 3'b000};
    logic [6:0] dv_f7    [14] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                  7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h01};
    logic [3:0] dv_op    [14] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0111, 4'b0110,
                                  4'b0101, 4'b0001, 4'b0000, 4'b1111, 4'b1111, 4'b1010, 4'b0000};
    logic       dv_md    [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        n_checks = 0;
        n_fail   = 0;
        last_exp = '0;
        reset    = 1'b0;
        aluop    = 4'b0000;
        func3    = 3'b000;
        func7    = 7'b0000000;
        valid_in = 1'b0;
        kill     = 1'b0;
        rs1_data = '0;
        rs2_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset md_valid", 32'(md_valid), 32'd0);
        check("reset md_result", md_result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset md_valid", 32'(md_valid), 32'd0);

        // Combinational decode
        for (int i = 0; i < 14; i++) begin
            aluop    = dv_aluop[i];
            func3    = dv_f3[i];
            func7    = dv_f7[i];
            valid_in = !dv_md[i];
            #1;
            check($sformatf("decode %0d aluoperation", i), 32'(aluoperation), 32'(dv_op[i]));
            check($sformatf("decode %0d is_md", i), 32'(is_md), 32'(dv_md[i]));
            check($sformatf("decode %0d stall", i), 32'(stall), 32'd0);
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);

        // Directed arithmetic
        do_md(3'd0, 32'd7,          32'hFFFF_FFFD, "mul 7x-3");
        check("mul 7x-3 constant", last_exp, 32'hFFFF_FFEB);
        do_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
        do_md(3'd2, 32'hFFFF_FFFF, 32'd2,         "mulhsu");
        do_md(3'd4, 32'hFFFF_FFF9, 32'd2,         "div -7/2");
        do_md(3'd6, 32'hFFFF_FFF9, 32'd2,         "rem -7/2");
        do_md(3'd5, 32'd5,          32'd0,         "divu by 0");
        do_md(3'd7, 32'd5,          32'd0,         "remu by 0");
        do_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        do_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");
        do_md(3'd4, 32'd100,        32'd0,         "div by 0");

        // kill in IDLE blocks acceptance of an otherwise one-cycle op
        aluop = 4'b0000; func7 = 7'b0000001; func3 = 3'd5;
        rs1_data = 32'd9; rs2_data = 32'd0; valid_in = 1'b1; kill = 1'b1;
        @(negedge clk);
        check("idle kill no valid", 32'(md_valid), 32'd0);
        check("idle kill result", md_result, last_exp);
        kill = 1'b0;
        @(negedge clk);
        check("idle kill then accept", 32'(md_valid), 32'd1);
        check("idle kill then result", md_result, 32'hFFFF_FFFF);
        last_exp = 32'hFFFF_FFFF;
        valid_in = 1'b0;
        @(negedge clk);

        // kill in RUN cycle 10
        aluop = 4'b0000; func7 = 7'b0000001; func3 = 3'd0;
        rs1_data = 32'd3; rs2_data = 32'd5; valid_in = 1'b1;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        check("run10 no valid yet", 32'(md_valid), 32'd0);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill no valid", 32'(md_valid), 32'd0);
        check("kill result kept", md_result, last_exp);
        // The FSM must be IDLE now: a one-cycle op is accepted immediately.
        do_md(3'd7, 32'd11, 32'd0, "after kill remu");

        // Asynchronous reset mid-RUN
        aluop = 4'b0000; func7 = 7'b0000001; func3 = 3'd0;
        rs1_data = 32'd6; rs2_data = 32'd9; valid_in = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset md_result", md_result, 32'd0);
        check("async reset md_valid", 32'(md_valid), 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_md(3'd0, 32'd7, 32'hFFFF_FFFD, "mul after reset");

        // Random M ops
        for (int i = 0; i < 24; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 5));
            else if (sel == 3) ra = 32'($urandom_range(0, 20));
            do_md(rf3, ra, rb, $sformatf("rand %0d f3=%0d", i, rf3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
